fifo_read_stream: RTL

//  Read-side engine for the FIFO_Control + RAM pair. Watches the FIFO empty flag and

---
 rtl/fifo_stream_pkg.sv | 16 +
 rtl/stream_skid_buf.sv | 70 +++++++
 rtl/fifo_read_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared helpers for the FIFO read-stream engine: parameter legality and
// sizing of the occupancy count.
package fifo_stream_pkg;

  // RAM read latencies the credit scheme is built for.
  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= 3);
  endfunction

  // Width of an occupancy count that must hold 0..depth inclusive;
  // callers build their occ_t typedef from this.
  function automatic int unsigned occ_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular output buffer: push at tail, pop from head, synchronous
// flush, occupancy count. Head word is presented combinationally.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUF_DEPTH  = 3,
  localparam int OCC_W      = occ_bits(BUF_DEPTH),
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_req,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W-1:0]      tail_ptr;
  logic                  pop;
  logic                  do_push;

  // Pointers wrap modulo BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (occupancy != '0);
  assign pop        = pop_req & head_valid;
  assign do_push    = push & ~flush;
  assign head_data  = head_valid ? mem[head_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) tail_ptr <= ptr_inc(tail_ptr);
      if (pop)     head_ptr <= ptr_inc(head_ptr);
      case ({do_push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: ;
      endcase
    end
  end

  // Data storage written at the tail.
  // NOTE: storage has no reset; occupancy guards every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

  // The credit rule upstream guarantees a free slot for every returning word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(do_push && occupancy == OCC_W'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side engine for a FIFO_Control + RAM pair: issues read strobes while
// buffer credit remains, tracks reads in flight through the RAM latency, and
// presents returned words as a valid/ready stream.
module fifo_read_stream
  import fifo_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int RD_LATENCY = 2,
  localparam int BUF_DEPTH  = RD_LATENCY + 1,
  localparam int OCC_W      = occ_bits(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]      occupancy
);

  typedef logic [OCC_W-1:0] occ_t;

  localparam logic [OCC_W:0] DEPTH_LIMIT = (OCC_W + 1)'(BUF_DEPTH);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("fifo_read_stream: RD_LATENCY must be in 1..3");
  end

  logic [RD_LATENCY-1:0] pipe;
  occ_t                  inflight;
  logic [OCC_W:0]        credit_used;
  logic                  push;

  // Count reads whose data has not yet come back from the RAM.
  // NOTE: combinational blocks use blocking (=) and assign every output first, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + occ_t'(pipe[i]);
    end
  end

  // Words already owned (buffered or in flight) against the buffer size;
  // m_ready is deliberately absent so there is no ready->read path.
  assign credit_used = {1'b0, occupancy} + {1'b0, inflight};
  assign fifo_read   = reset & ~fifo_empty & ~flush & (credit_used < DEPTH_LIMIT);

  // In-flight shift pipe: a bit enters with each strobe and leaves when its data lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else begin
      pipe[0] <= fifo_read;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // RAM data is valid exactly while the pipe tail is set; flush discards it.
  assign push = pipe[RD_LATENCY-1] & ~flush;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_data  (fifo_rdata),
    .pop_req    (m_ready),
    .head_valid (m_valid),
    .head_data  (m_data),
    .occupancy  (occupancy)
  );

endmodule
